// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word fetches, buffers in-order responses in a
// DEPTH-entry prefetch queue and hands one registered instr/PC pair per cycle to
// decode. A branch redirect flushes the queue and drops still-outstanding responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] PC,
    output logic        instr_valid
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = AW + 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]     head_q, head_d, tail_q, tail_d, rsp_ptr_q, rsp_ptr_d;
    // alloc: entries in the queue; pend: allocated entries still waiting for data;
    // drop: responses still to arrive for fetches flushed by a redirect
    logic [CW-1:0]     alloc_cnt_q, alloc_cnt_d;
    logic [CW-1:0]     pend_cnt_q, pend_cnt_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
    logic [DEPTH-1:0]  ok_q, ok_d;
    logic [31:0]       entry_pc_q   [DEPTH];
    logic [31:0]       entry_data_q [DEPTH];
    logic [31:0]       instr_q, instr_d, pc_out_q, pc_out_d;
    logic              instr_valid_q, instr_valid_d;

    logic [CW:0]       occupancy;
    logic              push, pop, rsp_drop, rsp_write;

    // Slots are consumed both by queued entries and by responses we still owe a drop.
    assign occupancy      = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};
    assign imem_req_valid = !redirect && (occupancy < DEPTH_C);
    assign imem_addr      = fetch_pc_q;
    assign push           = imem_req_valid && imem_req_ready;
    assign rsp_drop       = imem_rsp_valid && (drop_cnt_q != '0);
    assign rsp_write      = imem_rsp_valid && (drop_cnt_q == '0) && !redirect;
    // Only registered data_ok is looked at, so a response never pops in its own cycle.
    assign pop            = !redirect && !stall && ok_q[head_q];

    assign instr       = instr_q;
    assign PC          = pc_out_q;
    assign instr_valid = instr_valid_q;

    // Next-state for queue bookkeeping, fetch address and the decode-facing registers.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        rsp_ptr_d     = rsp_ptr_q;
        alloc_cnt_d   = alloc_cnt_q;
        pend_cnt_d    = pend_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        ok_d          = ok_q;
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;
        instr_valid_d = instr_valid_q;

        if (redirect) begin
            // Every pending entry becomes a response to drop; a response arriving now
            // (dropped or not) is one of those and is consumed this cycle.
            fetch_pc_d    = redirect_pc & 32'hFFFF_FFFC;
            head_d        = '0;
            tail_d        = '0;
            rsp_ptr_d     = '0;
            alloc_cnt_d   = '0;
            pend_cnt_d    = '0;
            ok_d          = '0;
            drop_cnt_d    = drop_cnt_q + pend_cnt_q - CW'(imem_rsp_valid);
            instr_d       = NOP;
            instr_valid_d = 1'b0;
        end else begin
            if (push) begin
                fetch_pc_d   = fetch_pc_q + 32'd4;
                tail_d       = tail_q + AW'(1);
                ok_d[tail_q] = 1'b0;
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (rsp_write) begin
                ok_d[rsp_ptr_q] = 1'b1;
                rsp_ptr_d       = rsp_ptr_q + AW'(1);
            end
            if (pop) begin
                ok_d[head_q] = 1'b0;
                head_d       = head_q + AW'(1);
            end
            alloc_cnt_d = alloc_cnt_q + CW'(push) - CW'(pop);
            pend_cnt_d  = pend_cnt_q + CW'(push) - CW'(rsp_write);

            if (stall) begin
                instr_d       = instr_q;
                pc_out_d      = pc_out_q;
                instr_valid_d = instr_valid_q;
            end else if (pop) begin
                instr_d       = entry_data_q[head_q];
                pc_out_d      = entry_pc_q[head_q];
                instr_valid_d = 1'b1;
            end else begin
                instr_d       = NOP;
                instr_valid_d = 1'b0;
            end
        end
    end

    // Control and output state, cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            head_q        <= '0;
            tail_q        <= '0;
            rsp_ptr_q     <= '0;
            alloc_cnt_q   <= '0;
            pend_cnt_q    <= '0;
            drop_cnt_q    <= '0;
            ok_q          <= '0;
            instr_q       <= NOP;
            pc_out_q      <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            rsp_ptr_q     <= rsp_ptr_d;
            alloc_cnt_q   <= alloc_cnt_d;
            pend_cnt_q    <= pend_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            ok_q          <= ok_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Entry payload storage; validity lives in ok_q, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_pc_q[tail_q] <= fetch_pc_q;
        end
        if (rsp_write) begin
            entry_data_q[rsp_ptr_q] <= imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a fixed-latency in-order memory model feeds
// words A0 + addr/4, and each observed cycle is compared with hand-derived values.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] instr;
    logic [31:0] PC;
    logic        instr_valid;

    int vectors     = 0;
    int miscompares = 0;
    int lat         = 1;
    int outs        = 0;

    typedef struct packed {
        logic [31:0] due;
        logic [31:0] data;
    } rsp_t;
    rsp_t        mq[$];
    rsp_t        r;
    logic [31:0] cyc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instr          (instr),
        .PC             (PC),
        .instr_valid    (instr_valid)
    );

    // Memory model: answers each accepted request lat cycles later, in order.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
            cyc            <= 32'h0;
            outs = 0;
        end else begin
            if (imem_rsp_valid) outs = outs - 1;
            if (imem_req_valid && imem_req_ready) begin
                outs = outs + 1;
                mq.push_back({cyc + 32'(lat) - 32'd1, 32'hA0 + (imem_addr >> 2)});
            end
            if (outs > 4) begin
                miscompares++;
                $display("FAIL outstanding: got %0d, limit 4", outs);
            end
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                r = mq.pop_front();
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= r.data;
            end else begin
                imem_rsp_valid <= 1'b0;
            end
            cyc <= cyc + 32'd1;
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One line per observed decode-side transaction, then three comparisons.
    task automatic observe(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
        $display("%t %s: valid=%0b PC=0x%08h instr=0x%08h", $time, tag, instr_valid, PC, instr);
        check_vec({tag, ".valid"}, {31'h0, instr_valid}, {31'h0, v});
        check_vec({tag, ".pc"}, PC, pc);
        check_vec({tag, ".instr"}, instr, ins);
    endtask

    task automatic start_reset(input int l);
        reset          = 1'b1;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        lat            = l;
        tick();
        tick();
    endtask

    logic [31:0] stream_pc [11];

    initial begin
        stream_pc = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8,
                      32'hC, 32'h10, 32'h14, 32'h18, 32'h1C};

        // Reset values, then streaming with a 3-cycle stall at PC 0x8
        start_reset(1);
        observe("reset", 1'b0, 32'h0, NOP);
        check_vec("reset.addr", imem_addr, 32'h0);
        reset = 1'b0;
        #1;
        check_vec("release.req_valid", {31'h0, imem_req_valid}, 32'h1);
        check_vec("release.addr", imem_addr, 32'h0);
        tick();
        observe("fill1", 1'b0, 32'h0, NOP);
        tick();
        observe("fill2", 1'b0, 32'h0, NOP);
        for (int i = 0; i < 11; i++) begin
            tick();
            observe($sformatf("stream%0d", i), 1'b1, stream_pc[i], 32'hA0 + (stream_pc[i] >> 2));
            stall = (i >= 2 && i <= 4);
        end
        stall = 1'b0;

        // Redirect with two fetches outstanding (3-cycle memory)
        start_reset(3);
        reset = 1'b0;
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        #1;
        check_vec("redir.req_valid", {31'h0, imem_req_valid}, 32'h0);
        tick();
        redirect = 1'b0;
        check_vec("redir.addr", imem_addr, 32'h100);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            observe($sformatf("drop%0d", i), 1'b0, 32'h0, NOP);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            observe($sformatf("after_redir%0d", i), 1'b1, 32'h100 + 32'(4 * i), 32'hE0 + 32'(i));
        end

        // Memory not ready for 5 cycles, then redirect together with stall
        start_reset(1);
        reset = 1'b0;
        tick();
        tick();
        tick();
        observe("c_first", 1'b1, 32'h0, 32'hA0);
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_vec($sformatf("notready%0d.addr", i), imem_addr, 32'hC);
            if (i == 0)      observe("notready0", 1'b1, 32'h4, 32'hA1);
            else if (i == 1) observe("notready1", 1'b1, 32'h8, 32'hA2);
            else             observe($sformatf("notready%0d", i), 1'b0, 32'h8, NOP);
        end
        imem_req_ready = 1'b1;
        tick();
        observe("resume0", 1'b0, 32'h8, NOP);
        tick();
        observe("resume1", 1'b0, 32'h8, NOP);
        tick();
        observe("resume2", 1'b1, 32'hC, 32'hA3);
        redirect    = 1'b1;
        stall       = 1'b1;
        redirect_pc = 32'h0000_0203;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        observe("redir_stall", 1'b0, 32'hC, NOP);
        check_vec("redir_stall.addr", imem_addr, 32'h200);
        tick();
        observe("rs_bubble0", 1'b0, 32'hC, NOP);
        tick();
        observe("rs_bubble1", 1'b0, 32'hC, NOP);
        tick();
        observe("rs_first", 1'b1, 32'h200, 32'h120);
        tick();
        observe("rs_second", 1'b1, 32'h204, 32'h121);

        // Fetch address wraps from 0xFFFF_FFFC to 0
        start_reset(1);
        reset       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        check_vec("wrap.addr", imem_addr, 32'h0);
        tick();
        observe("wrap0", 1'b1, 32'hFFFF_FFF8, 32'h4000_009E);
        tick();
        observe("wrap1", 1'b1, 32'hFFFF_FFFC, 32'h4000_009F);
        tick();
        observe("wrap2", 1'b1, 32'h0, 32'hA0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
